// File: rtl/mips_cache_pkg.sv
// Shared types and defaults for the cache memory-side arbiter.
package mips_cache_pkg;

  localparam int unsigned DefaultLineWords = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StRead  = 2'd2,
    StDone  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mips_cache_mem_arbiter.sv
// Owns the Avalon master: drains write-buffer transfers and issues read-miss line fills
// as sequential single-word reads, pre-empting writes only at transfer boundaries.
module mips_cache_mem_arbiter
  import mips_cache_pkg::*;
#(
  parameter int unsigned LINE_WORDS = DefaultLineWords,
  parameter int unsigned LINE_BITS  = $clog2(LINE_WORDS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_write_en,
  input  logic [31:0]          wb_addr,
  input  logic [31:0]          wb_data,
  input  logic [3:0]           wb_byteenable,
  output logic                 wb_waitrequest,
  output logic                 wb_active,
  input  logic                 rd_req,
  input  logic [31:0]          rd_addr,
  output logic [31:0]          rd_data,
  output logic [LINE_BITS-1:0] rd_word_idx,
  output logic                 rd_valid,
  output logic                 rd_done,
  output logic                 rd_busy,
  output logic [31:0]          avm_address,
  output logic                 avm_read,
  output logic                 avm_write,
  output logic [31:0]          avm_writedata,
  output logic [3:0]           avm_byteenable,
  input  logic [31:0]          avm_readdata,
  input  logic                 avm_waitrequest
);

  localparam logic [LINE_BITS-1:0] LastIdx = LINE_BITS'(LINE_WORDS - 1);

  arb_state_e           state_q, state_d;
  logic [LINE_BITS-1:0] cnt_q;
  logic [31:0]          base_q;
  logic                 rd_accept;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^rd_addr[LINE_BITS+1:0];
  assign rd_accept        = (state_q == StRead) && !avm_waitrequest;
  assign rd_busy          = (state_q == StRead) || (state_q == StDone);

  always_comb begin
    state_d        = state_q;
    wb_waitrequest = 1'b1;
    wb_active      = 1'b1;
    avm_address    = 32'h0;
    avm_read       = 1'b0;
    avm_write      = 1'b0;
    avm_writedata  = 32'h0;
    avm_byteenable = 4'h0;
    unique case (state_q)
      StIdle: begin
        if (rd_req) begin
          wb_active = 1'b0;
          state_d   = StRead;
        end else if (wb_write_en) begin
          avm_write      = 1'b1;
          avm_address    = wb_addr;
          avm_writedata  = wb_data;
          avm_byteenable = wb_byteenable;
          wb_waitrequest = avm_waitrequest;
          if (avm_waitrequest) state_d = StWrite;
        end
      end
      StWrite: begin
        // A started write must be held until accepted, even if a fill is waiting.
        avm_write      = 1'b1;
        avm_address    = wb_addr;
        avm_writedata  = wb_data;
        avm_byteenable = wb_byteenable;
        wb_waitrequest = avm_waitrequest;
        if (!avm_waitrequest) state_d = StIdle;
      end
      StRead: begin
        wb_active      = 1'b0;
        avm_read       = 1'b1;
        avm_address    = base_q + {{(30 - LINE_BITS){1'b0}}, cnt_q, 2'b00};
        avm_byteenable = 4'hF;
        if (rd_accept && (cnt_q == LastIdx)) state_d = StDone;
      end
      StDone: begin
        wb_active = 1'b0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Bus must be quiet during reset without waiting for a clock edge.
    if (rst) begin
      wb_waitrequest = 1'b1;
      avm_read       = 1'b0;
      avm_write      = 1'b0;
      avm_address    = 32'h0;
      avm_writedata  = 32'h0;
      avm_byteenable = 4'h0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      base_q      <= 32'h0;
      rd_data     <= 32'h0;
      rd_word_idx <= '0;
      rd_valid    <= 1'b0;
      rd_done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_valid <= 1'b0;
      rd_done  <= 1'b0;
      if ((state_q == StIdle) && rd_req) begin
        base_q <= {rd_addr[31:LINE_BITS+2], {(LINE_BITS + 2){1'b0}}};
        cnt_q  <= '0;
      end
      if (rd_accept) begin
        rd_data     <= avm_readdata;
        rd_word_idx <= cnt_q;
        rd_valid    <= 1'b1;
        rd_done     <= (cnt_q == LastIdx);
        cnt_q       <= cnt_q + 1'b1;
      end
    end
  end

endmodule
